issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- In-order issue controller between the RV64I decode stage and the EX stage.
- Tracks outstanding register writes per architectural register and stalls decode on RAW hazards or WAW counter saturation.
- Serialises control flow: one unresolved branch/jump at a time; fence/trap issue only with an empty pipeline.
- Holds issue after a trap until the trap handler releases it.

Parameters:
- MAX_INFLIGHT, 3, maximum issued-but-not-written-back instructions with rf_we=1 (1..7).
- CNT_W, 2, width of each per-register pending counter; must satisfy 2^CNT_W-1 >= 1.
- WB_BYPASS, 1, if 1 a writeback in the same cycle clears the hazard for a dependent issue (regfile is write-through).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  scoreboard accepts the instruction this cycle (combinational)
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rf_we  in  1  instruction writes rd
- id_rf_waddr  in  5  destination register
- id_bru_op  in  8  {jal,jalr,beq,bne,blt,bge,bltu,bgeu} one-hot or zero
- id_fence  in  1  fence or fence.i
- id_trap  in  1  ecall or ebreak
- issue_valid  out  1  id_valid & id_ready; EX captures on this
- wb_we  in  1  writeback strobe
- wb_waddr  in  5  writeback register
- br_resolve  in  1  EX has resolved the outstanding branch/jump (1-cycle pulse)
- trap_ret  in  1  release from HALT (1-cycle pulse)
- inflight  out  3  outstanding write count
- sb_state  out  2  00 RUN, 01 BR_WAIT, 10 HALT
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): all pending counters 0, inflight 0, state RUN, sb_err 0, id_ready 0.
- Register x0 is never marked pending; issue/wb with address 0 does not touch counters.
- Hazard on src s (s = rs1 if use_rs1, rs2 if use_rs2): pend[s] != 0.
  - With WB_BYPASS=1, the hazard is cleared if wb_we & wb_waddr==s & pend[s]==1.
- id_ready=1 only if all of the following hold:
  - state==RUN;
  - no source hazard;
  - if id_rf_we and rd != 0: pend[rd] not saturated, and inflight < MAX_INFLIGHT (a same-cycle wb counts as freeing a slot);
  - if id_fence|id_trap: inflight==0 after this cycle's wb.
- On issue:
  - rf_we with rd != 0: pend[rd]+1 and inflight+1.
  - |id_bru_op: RUN->BR_WAIT.
  - id_trap: RUN->HALT.
- On wb_we with addr != 0: pend[addr]-1 and inflight-1.
- Same-cycle issue and wb to the same rd: counter and inflight unchanged.
- Errors, set sb_err sticky until reset:
  - wb to a register with pend==0: counters unchanged.
  - br_resolve outside BR_WAIT: state unchanged.
  - trap_ret outside HALT: state unchanged.
- BR_WAIT->RUN on br_resolve. The first post-branch issue is possible the cycle after br_resolve (id_ready is registered-state based).
- HALT->RUN on trap_ret. Writebacks keep draining in BR_WAIT and HALT.
- Latency: issue is 0-cycle combinational. Counters update at the clock edge after issue/wb.
- Reset mid-operation discards all pending state. No flush input: in-order issue behind a branch guarantees no wrong-path writes.

Decomposition:
- Shared package holds:
  - SB_RUN/SB_BR_WAIT/SB_HALT state encodings;
  - BRU_OP bit indices matching the decoder's bru_op ordering;
  - REG_ZERO constant.
- One sub-module, sb_pend_file: 32 x CNT_W counters with inc/dec ports and a saturation/nonzero query. The top holds the FSM, ready logic and inflight counter.

Test Plan:
- Reset, then issue "add x5,x1,x2" -> issue_valid=1, next cycle pend[5]=1, inflight=1. Then "addi x6,x5,1" -> id_ready=0 until wb x5. With WB_BYPASS=1, ready in the same cycle as wb_we=1, wb_waddr=5.
- Three writes to x7 back to back with CNT_W=2 -> pend[7]=3; fourth write to x7 stalls. One wb x7 -> fourth issues, pend[7] stays 3.
- Issue beq -> sb_state=01, id_ready=0 for all following instructions. Pulse br_resolve -> sb_state=00 next cycle, issue resumes.
- With inflight=2, present fence -> stalled; two wb pulses -> fence issues in the cycle the last wb arrives. Ecall with inflight=0 -> HALT; trap_ret -> RUN.
- wb_we to x9 with pend[9]=0 -> sb_err=1 and stays 1. A br_resolve in RUN also keeps sb_err=1; counters are unchanged.
- Assert rst_n low while in BR_WAIT with inflight=3 -> immediately sb_state=00, inflight=0, id_ready=0 while rst_n is low.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the in-order issue scoreboard: FSM states,
// decoder branch-op bit positions and the hard-wired zero register.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_RUN     = 2'b00,
    SB_BR_WAIT = 2'b01,
    SB_HALT    = 2'b10
  } sb_state_e;

  // Bit positions within id_bru_op = {jal,jalr,beq,bne,blt,bge,bltu,bgeu}
  localparam int BRU_JAL  = 7;
  localparam int BRU_JALR = 6;
  localparam int BRU_BEQ  = 5;
  localparam int BRU_BNE  = 4;
  localparam int BRU_BLT  = 3;
  localparam int BRU_BGE  = 2;
  localparam int BRU_BLTU = 1;
  localparam int BRU_BGEU = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when any control-flow op bit is set
  function automatic logic is_ctrl_flow(input logic [7:0] bru_op);
    return bru_op[BRU_JAL]  | bru_op[BRU_JALR] | bru_op[BRU_BEQ]  | bru_op[BRU_BNE] |
           bru_op[BRU_BLT]  | bru_op[BRU_BGE]  | bru_op[BRU_BLTU] | bru_op[BRU_BGEU];
  endfunction

endpackage

// File: rtl/sb_pend_file.sv
// Per-architectural-register pending-write counters with one increment and
// one decrement port; x0 stays at zero. Queries are combinational reads.
module sb_pend_file
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [4:0]       inc_addr,
  input  logic             dec_en,
  input  logic [4:0]       dec_addr,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       wb_addr,
  output logic [CNT_W-1:0] rs1_cnt,
  output logic [CNT_W-1:0] rs2_cnt,
  output logic             rd_sat,
  output logic             wb_nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r [32];

  // Counter update: a simultaneous inc and dec on the same register cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      cnt_r[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (inc_en && (inc_addr == 5'(i)) && !(dec_en && (dec_addr == 5'(i)))) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_en && (dec_addr == 5'(i)) && !(inc_en && (inc_addr == 5'(i)))) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign rs1_cnt = cnt_r[rs1_addr];
  assign rs2_cnt = cnt_r[rs2_addr];
  assign rd_sat  = (cnt_r[rd_addr] == CNT_MAX);
  assign wb_nz   = (cnt_r[wb_addr] != '0) && (wb_addr != REG_ZERO);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: RAW/WAW hazard stall, in-flight write limit,
// single outstanding branch, and fence/trap serialisation with trap hold.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter int WB_BYPASS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_rf_we,
  input  logic [4:0] id_rf_waddr,
  input  logic [7:0] id_bru_op,
  input  logic       id_fence,
  input  logic       id_trap,
  output logic       issue_valid,
  input  logic       wb_we,
  input  logic [4:0] wb_waddr,
  input  logic       br_resolve,
  input  logic       trap_ret,
  output logic [2:0] inflight,
  output logic [1:0] sb_state,
  output logic       sb_err
);

  localparam logic [2:0]       MAX_IF  = 3'(MAX_INFLIGHT);
  localparam logic             BYP     = (WB_BYPASS != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_state_e        state_r, state_nxt_s;
  logic [2:0]       inflight_r, inflight_nxt_s, inflight_eff_s;
  logic             sb_err_r, sb_err_nxt_s;
  logic [CNT_W-1:0] rs1_cnt_s, rs2_cnt_s;
  logic             rd_sat_s, wb_nz_s;
  logic             wb_hit_s, wb_dec_s, wb_err_s, rd_wr_s, bru_s;
  logic             haz1_s, haz2_s, ready_s, issue_s, inc_en_s;

  assign wb_hit_s = wb_we && (wb_waddr != REG_ZERO);
  assign wb_dec_s = wb_hit_s && wb_nz_s;
  assign wb_err_s = wb_hit_s && !wb_nz_s;
  assign rd_wr_s  = id_rf_we && (id_rf_waddr != REG_ZERO);
  assign bru_s    = is_ctrl_flow(id_bru_op);
  // A same-cycle writeback already frees its slot for this cycle's decision
  assign inflight_eff_s = inflight_r - {2'b00, wb_dec_s};

  sb_pend_file #(.CNT_W(CNT_W)) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (inc_en_s),
    .inc_addr (id_rf_waddr),
    .dec_en   (wb_dec_s),
    .dec_addr (wb_waddr),
    .rs1_addr (id_rs1),
    .rs2_addr (id_rs2),
    .rd_addr  (id_rf_waddr),
    .wb_addr  (wb_waddr),
    .rs1_cnt  (rs1_cnt_s),
    .rs2_cnt  (rs2_cnt_s),
    .rd_sat   (rd_sat_s),
    .wb_nz    (wb_nz_s)
  );

  // Source RAW hazards, optionally cleared by the final pending writeback
  always_comb begin
    haz1_s = 1'b0;
    haz2_s = 1'b0;
    if (id_use_rs1 && (id_rs1 != REG_ZERO) && (rs1_cnt_s != '0)) begin
      haz1_s = !(BYP && wb_we && (wb_waddr == id_rs1) && (rs1_cnt_s == CNT_ONE));
    end else begin
      haz1_s = 1'b0;
    end
    if (id_use_rs2 && (id_rs2 != REG_ZERO) && (rs2_cnt_s != '0)) begin
      haz2_s = !(BYP && wb_we && (wb_waddr == id_rs2) && (rs2_cnt_s == CNT_ONE));
    end else begin
      haz2_s = 1'b0;
    end
  end

  // Issue acceptance; held low while reset is asserted
  always_comb begin
    ready_s = 1'b0;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (state_r != SB_RUN) begin
      ready_s = 1'b0;
    end else if (haz1_s || haz2_s) begin
      ready_s = 1'b0;
    end else if (rd_wr_s && (rd_sat_s || (inflight_eff_s >= MAX_IF))) begin
      ready_s = 1'b0;
    end else if ((id_fence || id_trap) && (inflight_eff_s != 3'd0)) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  assign issue_s  = id_valid && ready_s;
  assign inc_en_s = issue_s && rd_wr_s;

  // Control-flow FSM next state and sticky protocol error
  always_comb begin
    state_nxt_s  = state_r;
    sb_err_nxt_s = sb_err_r | wb_err_s;
    case (state_r)
      SB_RUN: begin
        if (issue_s && id_trap) begin
          state_nxt_s = SB_HALT;
        end else if (issue_s && bru_s) begin
          state_nxt_s = SB_BR_WAIT;
        end else begin
          state_nxt_s = SB_RUN;
        end
      end
      SB_BR_WAIT: begin
        if (br_resolve) begin
          state_nxt_s = SB_RUN;
        end else begin
          state_nxt_s = SB_BR_WAIT;
        end
      end
      SB_HALT: begin
        if (trap_ret) begin
          state_nxt_s = SB_RUN;
        end else begin
          state_nxt_s = SB_HALT;
        end
      end
      default: begin
        state_nxt_s = SB_RUN;
      end
    endcase
    if (br_resolve && (state_r != SB_BR_WAIT)) begin
      sb_err_nxt_s = 1'b1;
    end else if (trap_ret && (state_r != SB_HALT)) begin
      sb_err_nxt_s = 1'b1;
    end else begin
      sb_err_nxt_s = sb_err_nxt_s;
    end
  end

  // In-flight write count next value
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({inc_en_s, wb_dec_s})
      2'b10:   inflight_nxt_s = inflight_r + 3'd1;
      2'b01:   inflight_nxt_s = inflight_r - 3'd1;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // State, error and in-flight registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SB_RUN;
      inflight_r <= 3'd0;
      sb_err_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= inflight_nxt_s;
      sb_err_r   <= sb_err_nxt_s;
    end
  end

  assign id_ready    = ready_s;
  assign issue_valid = issue_s;
  assign inflight    = inflight_r;
  assign sb_state    = state_r;
  assign sb_err      = sb_err_r;

endmodule
